fifo_filler_mc: RTL and testbench

Multi-channel, parametrised FIFO filler: on `start` it streams `num_words` memory words per channel from a contiguous region over the Avalon-MM read master, unpacks each word LSB-first into `ELEM_W`-bit elements, and writes them into one of `NUM_CH` downstream FIFOs. It sits between the memory wrapper and the per-channel input FIFOs of the compute array. Compared with the single-channel filler, it handles back-pressure by stalling on `fifo_full`, supports multi-word transfers, and can abort safely.

---
 rtl/fifo_filler_mc.sv | 92 +++++++++
 tb/tb_fifo_filler_mc.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_filler_mc.sv
// fifo_filler_mc: streams num_words memory words per channel into NUM_CH FIFOs, LSB-first elements, with stall and safe abort
module fifo_filler_mc #(
    parameter int NUM_CH = 8,
    parameter int WORD_W = 64,
    parameter int ELEM_W = 8,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [WORD_W-1:0] mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest,
    input  logic [NUM_CH-1:0] fifo_full,
    output logic [NUM_CH-1:0] fifo_wren,
    output logic [ELEM_W-1:0] fifo_data
);
    localparam int EPW = WORD_W / ELEM_W;
    localparam int BPW = WORD_W / 8;
    localparam int EW  = EPW > 1 ? $clog2(EPW) : 1;
    localparam int CW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, PUSH, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] nw, word;
    logic [CW-1:0] ch;
    logic [EW-1:0] elem;
    logic [WORD_W-1:0] shift;
    logic wr, last_elem, last_word, last_ch;
    assign wr        = state == PUSH && !fifo_full[ch] && !abort;
    assign last_elem = elem == EW'(EPW - 1);
    assign last_word = word + CNT_W'(1) == nw;
    assign last_ch   = ch == CW'(NUM_CH - 1);
    assign busy      = state != IDLE;
    assign done      = state == DONE && !abort;
    assign mem_read  = state == REQ;
    assign fifo_wren = wr ? NUM_CH'(1) << ch : '0;
    assign fifo_data = wr ? shift[ELEM_W-1:0] : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = num_words == '0 ? DONE : REQ;
            REQ:     state_nx = abort ? IDLE : mem_waitrequest ? REQ : WAIT;
            // a response landing in the abort cycle is already consumed, so no drain is needed
            WAIT:    state_nx = abort ? (mem_readdatavalid ? IDLE : DRAIN) : mem_readdatavalid ? PUSH : WAIT;
            PUSH:    state_nx = abort ? IDLE : (wr && last_elem) ? ((last_word && last_ch) ? DONE : REQ) : PUSH;
            DRAIN:   if (mem_readdatavalid) state_nx = IDLE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_address <= '0;
            nw          <= '0;
            word        <= '0;
            ch          <= '0;
            elem        <= '0;
            shift       <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                mem_address <= base_addr;
                nw          <= num_words;
                word        <= '0;
                ch          <= '0;
                elem        <= '0;
            end
            if (state == REQ && !abort && !mem_waitrequest) mem_address <= mem_address + ADDR_W'(BPW);
            if (state == WAIT && mem_readdatavalid) begin
                shift <= mem_readdata;
                elem  <= '0;
            end
            if (wr) begin
                shift <= shift >> ELEM_W;
                elem  <= last_elem ? '0 : elem + EW'(1);
                if (last_elem) begin
                    word <= last_word ? '0 : word + CNT_W'(1);
                    if (last_word && !last_ch) ch <= ch + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_filler_mc.sv
// tb_fifo_filler_mc: directed scenarios with a transaction-level scoreboard of addresses, FIFO bytes and done timing
module tb_fifo_filler_mc;
    localparam int NCH = 2;
    logic clk = 0, rst, start, abort;
    logic [31:0] base_addr, mem_address;
    logic [15:0] num_words;
    logic busy, done, mem_read, mem_readdatavalid, mem_waitrequest;
    logic [63:0] mem_readdata;
    logic [1:0] fifo_full, fifo_wren;
    logic [7:0] fifo_data;
    int checks = 0, errors = 0;
    int lat, extra, ws_req, bp_req, clr_req;
    bit act, drain, pend;
    int pcnt, cyc, done_at, start_cyc, done_cyc, done_n, rd_hi, ws_seen, bp_seen, clr_seen, ws_left, bp_left;
    logic [31:0] paddr;
    logic [7:0] chq[NCH][$];
    logic [31:0] aq[$];
    logic [31:0] addr_log[$];
    logic [7:0] dlog[NCH][$];
    int wr_cyc[NCH][$];

    fifo_filler_mc #(.NUM_CH(2), .WORD_W(64), .ELEM_W(8), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest), .fifo_full(fifo_full),
        .fifo_wren(fifo_wren), .fifo_data(fifo_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(logic [31:0] a);
        return a == 32'h100 ? 64'h0807060504030201 : a == 32'h108 ? 64'h1817161514131211 : {a ^ 32'h5A5A0000, a + 32'h01010101};
    endfunction

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // memory/FIFO environment plus per-cycle scoreboard, all at mid-cycle
    initial begin : mon
        logic [63:0] w;
        int c;
        mem_readdatavalid = 0; mem_readdata = 0; mem_waitrequest = 0; fifo_full = 0;
        act = 0; drain = 0; pend = 0; cyc = 0; done_at = -1; done_cyc = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                addr_log.delete();
                for (int i = 0; i < NCH; i++) begin dlog[i].delete(); wr_cyc[i].delete(); end
                done_n = 0; rd_hi = 0; done_cyc = -1;
            end
            mem_readdatavalid = 0; mem_readdata = 0;
            if (pend) begin
                pcnt--;
                if (pcnt == 0) begin pend = 0; mem_readdatavalid = 1; mem_readdata = mem_word(paddr); end
            end
            if (ws_req != ws_seen && mem_read) begin ws_seen = ws_req; ws_left = 3; end
            mem_waitrequest = ws_left > 0;
            if (ws_left > 0) ws_left--;
            if (bp_req != bp_seen && dlog[0].size() == 3) begin bp_seen = bp_req; bp_left = 5; end
            fifo_full = {1'b0, bp_left > 0};
            if (bp_left > 0) bp_left--;
            #1;
            if (rst) begin
                act = 0; drain = 0; done_at = -1; aq.delete();
                for (int i = 0; i < NCH; i++) chq[i].delete();
                continue;
            end
            chk("busy", busy, act);
            chk("done", done, act && !drain && cyc == done_at);
            chk("wren_onehot", $countones(fifo_wren) <= 1, 1);
            if (!act || drain) begin
                chk("no_read", mem_read, 0);
                chk("no_write", fifo_wren, 0);
            end
            if (fifo_wren == 0) chk("data_idle", fifo_data, 0);
            else begin
                c = fifo_wren[1] ? 1 : 0;
                chk("fifo_data", fifo_data, chq[c].size() ? chq[c][0] : 8'hxx);
                if (chq[c].size()) void'(chq[c].pop_front());
                if (c == 1) chk("ch_order", chq[0].size(), 0);
                dlog[c].push_back(fifo_data);
                wr_cyc[c].push_back(cyc);
            end
            if (mem_read) begin
                rd_hi++;
                chk("mem_address", mem_address, aq.size() ? aq[0] : 32'hDEADBEEF);
                if (!mem_waitrequest) begin
                    addr_log.push_back(mem_address);
                    if (aq.size()) void'(aq.pop_front());
                    pend = 1; pcnt = lat; paddr = mem_address;
                end
            end
            if (done) begin
                done_n++; done_cyc = cyc;
                chk("queues_empty", chq[0].size() + chq[1].size() + aq.size(), 0);
            end
            if (act && !drain && cyc == done_at) act = 0;
            if (drain && mem_readdatavalid) begin drain = 0; act = 0; end
            if (abort && act && !drain) begin
                aq.delete(); chq[0].delete(); chq[1].delete(); done_at = -1;
                if (pend) drain = 1; else act = 0;
            end
            if (start && !act) begin
                act = 1; drain = 0; start_cyc = cyc;
                done_at = num_words == 0 ? cyc + 1 : cyc + NCH * num_words * 10 + 1 + extra;
                for (int ch = 0; ch < NCH; ch++)
                    for (int wi = 0; wi < int'(num_words); wi++) begin
                        paddr = base_addr + 32'((ch * int'(num_words) + wi) * 8);
                        aq.push_back(paddr);
                        w = mem_word(paddr);
                        for (int e = 0; e < 8; e++) chq[ch].push_back(w[8*e +: 8]);
                    end
            end
        end
    end

    task automatic clear_logs();
        clr_req++;
        @(negedge clk); #2;
    endtask

    task automatic start_xfer(logic [31:0] b, logic [15:0] n, int ex);
        @(posedge clk); #1;
        base_addr = b; num_words = n; extra = ex; start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin @(posedge clk); #1; n++; end
        chk("idle_reached", busy, 0);
    endtask

    initial begin : main
        logic [31:0] wrap_exp [6];
        logic [63:0] w;
        int n;
        wrap_exp = '{32'hFFFFFFF0, 32'hFFFFFFF8, 32'h0, 32'h8, 32'h10, 32'h18};
        rst = 1; start = 0; abort = 0; base_addr = 0; num_words = 0;
        lat = 1; extra = 0; ws_req = 0; bp_req = 0; clr_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_read", mem_read, 0);
        chk("rst_addr", mem_address, 0); chk("rst_wren", fifo_wren, 0); chk("rst_data", fifo_data, 0);
        rst = 0;
        clear_logs(); start_xfer(32'h100, 1, 0); wait_idle();
        chk("basic_addr0", addr_log.size() > 0 ? addr_log[0] : 0, 32'h100);
        chk("basic_addr1", addr_log.size() > 1 ? addr_log[1] : 0, 32'h108);
        chk("basic_n0", dlog[0].size(), 8); chk("basic_n1", dlog[1].size(), 8);
        chk("basic_ch0_first", dlog[0].size() == 8 ? dlog[0][0] : 0, 8'h01);
        chk("basic_ch0_last", dlog[0].size() == 8 ? dlog[0][7] : 0, 8'h08);
        chk("basic_ch1_first", dlog[1].size() == 8 ? dlog[1][0] : 0, 8'h11);
        chk("basic_ch1_last", dlog[1].size() == 8 ? dlog[1][7] : 0, 8'h18);
        chk("basic_done_n", done_n, 1); chk("basic_done_lat", done_cyc - start_cyc, 21);
        clear_logs(); start_xfer(32'hFFFFFFF0, 3, 0); wait_idle();
        chk("wrap_reads", addr_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("wrap_addr", addr_log.size() > i ? addr_log[i] : 32'hDEADBEEF, wrap_exp[i]);
        chk("wrap_n0", dlog[0].size(), 24); chk("wrap_n1", dlog[1].size(), 24);
        chk("wrap_done_lat", done_cyc - start_cyc, 61);
        clear_logs(); bp_req++; start_xfer(32'h200, 1, 5); wait_idle();
        chk("bp_n0", dlog[0].size(), 8); chk("bp_n1", dlog[1].size(), 8);
        chk("bp_gap", wr_cyc[0].size() > 3 ? wr_cyc[0][3] - wr_cyc[0][2] : 0, 6);
        chk("bp_done_lat", done_cyc - start_cyc, 26);
        clear_logs(); ws_req++; start_xfer(32'h300, 1, 3); wait_idle();
        chk("ws_reads", addr_log.size(), 2); chk("ws_read_cycles", rd_hi, 5);
        chk("ws_done_lat", done_cyc - start_cyc, 24);
        clear_logs(); lat = 4; start_xfer(32'h400, 1, 0);
        n = 0;
        while (addr_log.size() == 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("abort_setup", addr_log.size(), 1);
        abort = 1;
        @(posedge clk); #1;
        abort = 0; base_addr = 32'h500; num_words = 1; start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("drain_busy", busy, 1);
        wait_idle();
        chk("abort_no_done", done_n, 0);
        chk("abort_no_write", dlog[0].size() + dlog[1].size(), 0);
        chk("abort_one_read", addr_log.size(), 1);
        lat = 1;
        clear_logs(); start_xfer(32'h500, 1, 0); wait_idle();
        w = mem_word(32'h500);
        chk("fresh_first", dlog[0].size() ? dlog[0][0] : 0, w[7:0]);
        chk("fresh_done_n", done_n, 1); chk("fresh_done_lat", done_cyc - start_cyc, 21);
        clear_logs(); start_xfer(32'h600, 0, 0); wait_idle();
        chk("zero_done_lat", done_cyc - start_cyc, 1); chk("zero_done_n", done_n, 1);
        chk("zero_reads", rd_hi, 0); chk("zero_writes", dlog[0].size() + dlog[1].size(), 0);
        clear_logs(); start_xfer(32'h700, 1, 0);
        n = 0;
        while (dlog[0].size() < 3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("rst_setup", dlog[0].size(), 3);
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0); chk("mid_rst_read", mem_read, 0);
        chk("mid_rst_addr", mem_address, 0); chk("mid_rst_wren", fifo_wren, 0); chk("mid_rst_data", fifo_data, 0);
        rst = 0;
        clear_logs(); start_xfer(32'h100, 1, 0); wait_idle();
        chk("post_rst_last", dlog[1].size() == 8 ? dlog[1][7] : 0, 8'h18);
        chk("post_rst_done_lat", done_cyc - start_cyc, 21);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
